// File: rtl/hcs_alu_pkg.sv
// Shared encodings for the health-check ALU path: sequencer states and opcodes.
package hcs_alu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_ctrl_if.sv
// Request/response bundle between the measurement logic and the serial add/sub sequencer.
interface serial_addsub_ctrl_if #(
  parameter int unsigned WIDTH = 8
);

  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output start, sub, a, b,
    input  busy, done, result, cout, ovf, zero
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, result, cout, ovf, zero
  );

endinterface

// File: rtl/addsub_bit_cell.sv
// Combinational 1-bit add/subtract cell; b is inverted here when subtracting.
module addsub_bit_cell
  import hcs_alu_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic sub,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic b_eff;

  assign b_eff = (sub == OP_SUB) ? ~b : b;
  assign s     = a ^ b_eff ^ cin;
  assign cout  = (a & b_eff) | (a & cin) | (b_eff & cin);

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/sub sequencer: one shared 1-bit cell iterated LSB first over WIDTH cycles.
module serial_addsub_ctrl
  import hcs_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input logic                clk,
  input logic                rst_n,
  serial_addsub_ctrl_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_next;
  logic             sub_q;
  logic             carry;
  logic             cell_s;
  logic             cell_co;
  logic             last_bit;

  addsub_bit_cell u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .sub  (sub_q),
    .cin  (carry),
    .s    (cell_s),
    .cout (cell_co)
  );

  assign res_next = {cell_s, res_sr[WIDTH-1:1]};
  assign last_bit = (cnt == CW'(WIDTH - 1));

  // Sequencer; flags are loaded on the edge that enters DONE, while carry still
  // holds the carry into the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      sub_q      <= 1'b0;
      carry      <= 1'b0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.result <= '0;
      bus.cout   <= 1'b0;
      bus.ovf    <= 1'b0;
      bus.zero   <= 1'b1;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            a_sr     <= bus.a;
            b_sr     <= bus.b;
            sub_q    <= bus.sub;
            carry    <= bus.sub;
            cnt      <= '0;
            state    <= ST_RUN;
            bus.busy <= 1'b1;
          end else begin
            state    <= ST_IDLE;
            bus.busy <= 1'b0;
          end
        end
        ST_RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_next;
          carry  <= cell_co;
          cnt    <= cnt + CW'(1);
          if (last_bit) begin
            state      <= ST_DONE;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b1;
            bus.result <= res_next;
            bus.cout   <= cell_co;
            bus.ovf    <= carry ^ cell_co;
            bus.zero   <= (res_next == '0);
          end
        end
        default: begin
          state    <= ST_IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Scoreboard bench for serial_addsub_ctrl at WIDTH = 8.
module tb_serial_addsub_ctrl;

  localparam int unsigned WIDTH = 8;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;
    logic             zero;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  serial_addsub_ctrl_if #(.WIDTH(WIDTH)) bus ();

  serial_addsub_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  obs_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  // Word-level reference: wide add, overflow from operand/result signs.
  function automatic obs_t model(input logic [7:0] a, input logic [7:0] b, input logic sub);
    logic [8:0] s;
    logic [7:0] bb;
    obs_t       r;
    bb       = sub ? ~b : b;
    s        = {1'b0, a} + {1'b0, bb} + 9'(sub);
    r.result = s[7:0];
    r.cout   = s[8];
    r.ovf    = (a[7] == bb[7]) && (s[7] != a[7]);
    r.zero   = (s[7:0] == 8'h00);
    return r;
  endfunction

  function automatic obs_t snap();
    return {bus.result, bus.cout, bus.ovf, bus.zero};
  endfunction

  // Called at a negedge: present a request and record its expected outcome.
  task automatic drive_start(input logic [7:0] a, input logic [7:0] b, input logic sub);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.sub   = sub;
    exp_q.push_back(model(a, b, sub));
  endtask

  // Watch ncyc cycles after a start; optionally pulse a stray start at pulse_cyc.
  task automatic observe(input int ncyc, input int pulse_cyc,
                         output int done_cyc, output int ndone,
                         output logic [31:0] busy_mask, output obs_t got);
    done_cyc  = 0;
    ndone     = 0;
    busy_mask = '0;
    got       = '0;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      if (k == 1) bus.start = 1'b0;
      if (busy_mask[31] == 1'b0 && bus.busy) busy_mask[k] = 1'b1;
      if (bus.done) begin
        ndone++;
        if (done_cyc == 0) begin
          done_cyc = k;
          got      = snap();
        end
      end
      if (pulse_cyc != 0 && k == pulse_cyc) begin
        bus.start = 1'b1;
        bus.a     = 8'hC3;
        bus.b     = 8'h3C;
        bus.sub   = ~bus.sub;
      end
      if (pulse_cyc != 0 && k == pulse_cyc + 1) bus.start = 1'b0;
    end
  endtask

  task automatic test_reset();
    obs_t        e, got;
    int          dc, nd;
    logic [31:0] bm;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.sub = 1'b0; bus.a = '0; bus.b = '0;
    repeat (2) @(negedge clk);
    n_assert++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      n_fail++; $display("FAIL reset_ctrl busy/done got %b want 00", {bus.busy, bus.done});
    end
    n_assert++;
    if (snap() !== obs_t'({8'h00, 1'b0, 1'b0, 1'b1})) begin
      n_fail++; $display("FAIL reset_flags got %h want %h", snap(), obs_t'({8'h00, 1'b0, 1'b0, 1'b1}));
    end
    rst_n = 1'b1;
    @(negedge clk);
    drive_start(8'h35, 8'h1A, 1'b0);
    observe(12, 0, dc, nd, bm, got);
    e = exp_q.pop_front();
    n_assert++;
    if (dc !== 9) begin n_fail++; $display("FAIL reset_op_done_cycle got %0d want 9", dc); end
    n_assert++;
    if (nd !== 1) begin n_fail++; $display("FAIL reset_op_done_count got %0d want 1", nd); end
    n_assert++;
    if (bm !== 32'h0000_01FE) begin n_fail++; $display("FAIL reset_op_busy_mask got %h want 000001fe", bm); end
    n_assert++;
    if (got !== e) begin n_fail++; $display("FAIL reset_op_result got %h want %h", got, e); end
  endtask

  // Runs each listed operation alone and checks timing plus result.
  task automatic run_list(input string tag, input logic [7:0] av[$], input logic [7:0] bv[$], input logic sv[$]);
    obs_t        e, got;
    int          dc, nd;
    logic [31:0] bm;
    for (int i = 0; i < av.size(); i++) begin
      @(negedge clk);
      drive_start(av[i], bv[i], sv[i]);
      observe(11, 0, dc, nd, bm, got);
      e = exp_q.pop_front();
      n_assert++;
      if (dc !== 9 || nd !== 1) begin
        n_fail++; $display("FAIL %s[%0d]_done got cyc %0d cnt %0d want cyc 9 cnt 1", tag, i, dc, nd);
      end
      n_assert++;
      if (got !== e) begin n_fail++; $display("FAIL %s[%0d]_result got %h want %h", tag, i, got, e); end
    end
  endtask

  task automatic test_overflow();
    run_list("ovf", '{8'h7F, 8'hFF}, '{8'h01, 8'h01}, '{1'b0, 1'b0});
  endtask

  task automatic test_subtract();
    run_list("sub", '{8'h10, 8'h55, 8'h80}, '{8'h20, 8'h55, 8'h01}, '{1'b1, 1'b1, 1'b1});
  endtask

  task automatic test_busy_reject();
    obs_t        e, got;
    int          dc, nd;
    logic [31:0] bm;
    @(negedge clk);
    drive_start(8'h64, 8'h27, 1'b1);
    observe(14, 3, dc, nd, bm, got);
    e = exp_q.pop_front();
    n_assert++;
    if (nd !== 1) begin n_fail++; $display("FAIL busy_reject_done_count got %0d want 1", nd); end
    n_assert++;
    if (dc !== 9) begin n_fail++; $display("FAIL busy_reject_done_cycle got %0d want 9", dc); end
    n_assert++;
    if (got !== e) begin n_fail++; $display("FAIL busy_reject_result got %h want %h", got, e); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] av[4] = '{8'h12, 8'h90, 8'hA5, 8'h3C};
    logic [7:0] bv[4] = '{8'h34, 8'h90, 8'h5B, 8'h0F};
    logic       sv[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    obs_t       e;
    @(negedge clk);
    drive_start(av[0], bv[0], sv[0]);
    for (int i = 0; i < 4; i++) begin
      for (int k = 1; k <= 9; k++) begin
        @(negedge clk);
        n_assert++;
        if (k < 9) begin
          if ({bus.busy, bus.done} !== 2'b10) begin
            n_fail++; $display("FAIL b2b[%0d]_run_c%0d busy/done got %b want 10", i, k, {bus.busy, bus.done});
          end
        end else begin
          if ({bus.busy, bus.done} !== 2'b01) begin
            n_fail++; $display("FAIL b2b[%0d]_done busy/done got %b want 01", i, {bus.busy, bus.done});
          end
          e = exp_q.pop_front();
          n_assert++;
          if (snap() !== e) begin n_fail++; $display("FAIL b2b[%0d]_result got %h want %h", i, snap(), e); end
          if (i < 3) drive_start(av[i+1], bv[i+1], sv[i+1]);
          else bus.start = 1'b0;
        end
      end
    end
    @(negedge clk);
    n_assert++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      n_fail++; $display("FAIL b2b_idle busy/done got %b want 00", {bus.busy, bus.done});
    end
  endtask

  task automatic test_reset_mid();
    int ndone;
    @(negedge clk);
    drive_start(8'h4D, 8'h22, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) bus.start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    void'(exp_q.pop_front());
    n_assert++;
    if ({bus.busy, bus.done, snap()} !== {2'b00, obs_t'({8'h00, 1'b0, 1'b0, 1'b1})}) begin
      n_fail++; $display("FAIL reset_mid_outputs got %h want %h", {bus.busy, bus.done, snap()},
                         {2'b00, obs_t'({8'h00, 1'b0, 1'b0, 1'b1})});
    end
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    n_assert++;
    if (ndone !== 0) begin n_fail++; $display("FAIL reset_mid_no_done got %0d want 0", ndone); end
    run_list("after_reset", '{8'hC8}, '{8'h4B}, '{1'b1});
  endtask

  initial begin
    test_reset();
    test_overflow();
    test_subtract();
    test_busy_reject();
    test_back_to_back();
    test_reset_mid();
    n_assert++;
    if (exp_q.size() !== 0) begin n_fail++; $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
